// File: rtl/mix_seq_ctrl.sv
// Mixer/comparator front-end sequencer: settle delay, sample/compare strobes, word capture, valid/ready output.
// Build option MIX_SEQ_OVF_CNT_EN adds ovf_cnt, an 8-bit saturating count of dropped words.
module mix_seq_ctrl #(
    parameter int DIV       = 10,
    parameter int CMP_PHASE = 3,
    parameter int SETTLE    = 16,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cmp_in,
    output logic              smp_stb,
    output logic              cmp_stb,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
    output logic              ovf
`ifdef MIX_SEQ_OVF_CNT_EN
    ,
    output logic [7:0]        ovf_cnt
`endif
);

    localparam int PW          = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int SW          = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam int BW          = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam int SETTLE_LAST = (SETTLE >= 2) ? SETTLE - 2 : 0;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_DRAIN} state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     settle_cnt;
    logic [PW-1:0]     phase, phase_d;
    logic [BW-1:0]     bit_cnt;
    logic [WORD_W-2:0] shreg;
    logic [WORD_W-1:0] word_nxt;
    logic              smp_d, cmp_d, word_done, xfer;

    assign word_nxt  = {shreg, cmp_in};
    assign word_done = cmp_stb && (bit_cnt == BW'(WORD_W - 1));
    assign xfer      = data_valid && data_ready;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // The IDLE cycle that samples en counts toward the settle interval,
    // so the first RUN cycle lands exactly SETTLE cycles after en is seen.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (en) state_nxt = (SETTLE == 1) ? S_RUN : S_SETTLE;
            S_SETTLE: begin
                if (!en)                                 state_nxt = S_IDLE;
                else if (settle_cnt == SW'(SETTLE_LAST)) state_nxt = S_RUN;
            end
            S_RUN:    if (!en) state_nxt = S_DRAIN;
            S_DRAIN:  if (!data_valid || data_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        phase_d = '0;
        smp_d   = 1'b0;
        cmp_d   = 1'b0;
        if (state_nxt == S_RUN) begin
            if (state == S_RUN && phase != PW'(DIV - 1)) phase_d = phase + 1'b1;
            smp_d = (phase_d == '0);
            cmp_d = (phase_d == PW'(CMP_PHASE));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            phase      <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            smp_stb    <= 1'b0;
            cmp_stb    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            ovf        <= 1'b0;
`ifdef MIX_SEQ_OVF_CNT_EN
            ovf_cnt    <= '0;
`endif
        end else begin
            smp_stb    <= smp_d;
            cmp_stb    <= cmp_d;
            phase      <= phase_d;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;

            if (state != S_RUN) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (cmp_stb) begin
                shreg   <= word_nxt[WORD_W-2:0];
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end

            if (word_done && (!data_valid || data_ready)) begin
                data_out   <= word_nxt;
                data_valid <= 1'b1;
            end else if (xfer) begin
                data_valid <= 1'b0;
            end

            if (state == S_IDLE && en) begin
                ovf <= 1'b0;
`ifdef MIX_SEQ_OVF_CNT_EN
                ovf_cnt <= '0;
`endif
            end else if (word_done && data_valid && !data_ready) begin
                ovf <= 1'b1;
`ifdef MIX_SEQ_OVF_CNT_EN
                if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mix_seq_ctrl.sv
// Self-checking bench for mix_seq_ctrl: timing model plus output-word scoreboard.
module tb_mix_seq_ctrl;

    localparam int DIV       = 10;
    localparam int CMP_PHASE = 3;
    localparam int SETTLE    = 16;
    localparam int WORD_W    = 8;

    logic              clk, rst_n, en, cmp_in, data_ready;
    logic              smp_stb, cmp_stb, data_valid, busy, ovf;
    logic [WORD_W-1:0] data_out;
`ifdef MIX_SEQ_OVF_CNT_EN
    logic [7:0]        ovf_cnt;
`endif

    mix_seq_ctrl #(.DIV(DIV), .CMP_PHASE(CMP_PHASE), .SETTLE(SETTLE), .WORD_W(WORD_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cmp_in(cmp_in),
        .smp_stb(smp_stb), .cmp_stb(cmp_stb), .data_out(data_out),
        .data_valid(data_valid), .data_ready(data_ready), .busy(busy), .ovf(ovf)
`ifdef MIX_SEQ_OVF_CNT_EN
        , .ovf_cnt(ovf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Bench model: cycle index relative to en rising, RUN tracking, pending word.
    int                cyc;
    int                m_start;
    bit                m_run;
    int                m_run_cyc;
    int                m_nb;
    bit                m_done;
    bit                m_valid;
    bit                m_ovf;
    int                m_ovf_cnt;
    logic [WORD_W-1:0] m_sr;
    logic [WORD_W-1:0] exp_q[$];
    bit                feed_q[$];

    task automatic model_clear();
        m_start = -1; m_run = 0; m_run_cyc = 0; m_nb = 0; m_done = 0;
        m_valid = 0; m_ovf = 0; m_ovf_cnt = 0; m_sr = '0;
        exp_q.delete(); feed_q.delete();
    endtask

    task automatic load_word(input logic [WORD_W-1:0] w);
        for (int i = WORD_W - 1; i >= 0; i--) feed_q.push_back(w[i]);
    endtask

    // One clock: retire/load words at the edge, then check strobes and flags.
    task automatic step();
        bit hs, nxt_run, b, exp_smp, exp_cmp;
        logic [WORD_W-1:0] exp_w;
        hs = m_valid && data_ready;
        if (hs) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_underflow: got word %0h, required none pending", data_out);
            end else begin
                exp_w = exp_q.pop_front();
                if (data_out !== exp_w) begin
                    n_errors++;
                    $display("FAIL sb_word: got %0h required %0h (cyc %0d)", data_out, exp_w, cyc);
                end
            end
        end
        if (m_done) begin
            if (!m_valid || hs) begin
                exp_q.push_back(m_sr);
                m_valid = 1;
            end else begin
                m_ovf = 1;
                if (m_ovf_cnt < 255) m_ovf_cnt++;
            end
        end else if (hs) begin
            m_valid = 0;
        end
        m_done = 0;
        if (!m_run && m_start == cyc && en) begin
            m_ovf = 0;
            m_ovf_cnt = 0;
        end
        nxt_run = m_run ? en : (m_start >= 0 && en && (cyc + 1 == m_start + SETTLE));
        if (!en) m_start = -1;

        @(posedge clk); #1;
        cyc++;
        if (nxt_run && !m_run) m_run_cyc = 0;
        else                   m_run_cyc++;
        if (!nxt_run) begin
            m_nb = 0;
            m_sr = '0;
        end
        m_run   = nxt_run;
        exp_smp = m_run && (m_run_cyc % DIV == 0);
        exp_cmp = m_run && (m_run_cyc % DIV == CMP_PHASE);

        n_checks += 4;
        if (smp_stb !== exp_smp) begin
            n_errors++;
            $display("FAIL smp_stb: got %b required %b (cyc %0d)", smp_stb, exp_smp, cyc);
        end
        if (cmp_stb !== exp_cmp) begin
            n_errors++;
            $display("FAIL cmp_stb: got %b required %b (cyc %0d)", cmp_stb, exp_cmp, cyc);
        end
        if (data_valid !== m_valid) begin
            n_errors++;
            $display("FAIL data_valid: got %b required %b (cyc %0d)", data_valid, m_valid, cyc);
        end
        if (ovf !== m_ovf) begin
            n_errors++;
            $display("FAIL ovf: got %b required %b (cyc %0d)", ovf, m_ovf, cyc);
        end
`ifdef MIX_SEQ_OVF_CNT_EN
        n_checks++;
        if (ovf_cnt !== 8'(m_ovf_cnt)) begin
            n_errors++;
            $display("FAIL ovf_cnt: got %0d required %0d (cyc %0d)", ovf_cnt, m_ovf_cnt, cyc);
        end
`endif

        if (exp_cmp) begin
            b = (feed_q.size() != 0) ? feed_q.pop_front() : 1'($urandom_range(0, 1));
            cmp_in = b;
            m_sr = {m_sr[WORD_W-2:0], b};
            m_nb++;
            if (m_nb == WORD_W) begin
                m_done = 1;
                m_nb = 0;
            end
        end else begin
            cmp_in = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic stop_to_idle();
        int guard;
        en = 1'b0;
        data_ready = 1'b1;
        step();
        guard = 0;
        while (busy && guard < 20) begin
            step();
            guard++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_timeout: busy got %b required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; cmp_in = 1'b0; data_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            cmp_in = ~cmp_in;
        end
        n_checks++;
        if ({smp_stb, cmp_stb, data_valid, busy, ovf, data_out} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got smp=%b cmp=%b dv=%b busy=%b ovf=%b data=%0h required all 0",
                     smp_stb, cmp_stb, data_valid, busy, ovf, data_out);
        end
        en = 1'b0;
        rst_n = 1'b1;
        model_clear();
        cyc = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (busy !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_idle_busy: got %b required 0", busy);
            end
        end
    endtask

    task automatic test_word();
        data_ready = 1'b1;
        load_word(8'b1011_0010);
        cyc = 0; m_start = 0; en = 1'b1;
        while (cyc < 95) begin
            step();
            if (cyc == 1) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL start_busy: got %b required 1", busy);
                end
            end
            if (cyc == 16 || cyc == 26) begin
                n_checks++;
                if (smp_stb !== 1'b1) begin
                    n_errors++;
                    $display("FAIL start_smp: got %b required 1 at cyc %0d", smp_stb, cyc);
                end
            end
            if (cyc == 19) begin
                n_checks++;
                if (cmp_stb !== 1'b1) begin
                    n_errors++;
                    $display("FAIL start_cmp: got %b required 1", cmp_stb);
                end
            end
            if (cyc == 89 || cyc == 91) begin
                n_checks++;
                if (data_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL word_valid_edge: got %b required 0 at cyc %0d", data_valid, cyc);
                end
            end
            if (cyc == 90) begin
                n_checks += 3;
                if (data_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL word_valid: got %b required 1", data_valid);
                end
                if (data_out !== 8'hB2) begin
                    n_errors++;
                    $display("FAIL word_data: got %0h required b2", data_out);
                end
                if (ovf !== 1'b0) begin
                    n_errors++;
                    $display("FAIL word_ovf: got %b required 0", ovf);
                end
            end
        end
        stop_to_idle();
    endtask

    task automatic test_overflow();
        data_ready = 1'b0;
        load_word(8'h5A); load_word(8'hC3); load_word(8'h96);
        cyc = 0; m_start = 0; en = 1'b1;
        run_to(169);
        n_checks++;
        if (ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_early: got %b required 0", ovf);
        end
        step();
        n_checks += 2;
        if (ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_set: got %b required 1", ovf);
        end
        if (data_out !== 8'h5A) begin
            n_errors++;
            $display("FAIL ovf_hold: got %0h required 5a", data_out);
        end
`ifdef MIX_SEQ_OVF_CNT_EN
        n_checks++;
        if (ovf_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL ovf_cnt_one: got %0d required 1", ovf_cnt);
        end
`endif
        run_to(171);
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        n_checks++;
        if (data_valid !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL ovf_single_xfer: got dv=%b pending=%0d required 0/0", data_valid, exp_q.size());
        end
    endtask

    task automatic test_stop_mid_word();
        run_to(251);
        n_checks++;
        if (data_out !== 8'h96 || data_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL stop_word3: got %0h dv=%b required 96 dv=1", data_out, data_valid);
        end
        run_to(280);
        en = 1'b0;
        step();
        n_checks++;
        if ({smp_stb, cmp_stb, busy} !== 3'b001) begin
            n_errors++;
            $display("FAIL stop_drain: got smp=%b cmp=%b busy=%b required 0 0 1", smp_stb, cmp_stb, busy);
        end
        while (cyc < 285) begin
            step();
            n_checks++;
            if (busy !== 1'b1) begin
                n_errors++;
                $display("FAIL drain_hold: busy got %b required 1 at cyc %0d", busy, cyc);
            end
        end
        data_ready = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_exit: got busy=%b dv=%b required 0 0", busy, data_valid);
        end
        run_to(300);
        n_checks += 2;
        if (exp_q.size() != 0 || data_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL no_partial: got pending=%0d dv=%b required 0 0", exp_q.size(), data_valid);
        end
        if (ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_sticky_idle: got %b required 1", ovf);
        end
    endtask

    task automatic test_async_reset();
        data_ready = 1'b1;
        cyc = 0; m_start = 0; en = 1'b1;
        run_to(46);
        n_checks++;
        if (smp_stb !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_pre: smp got %b required 1", smp_stb);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({smp_stb, cmp_stb, data_valid, busy, ovf, data_out} !== '0) begin
            n_errors++;
            $display("FAIL areset_outputs: got smp=%b cmp=%b dv=%b busy=%b ovf=%b data=%0h required all 0",
                     smp_stb, cmp_stb, data_valid, busy, ovf, data_out);
        end
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst_n = 1'b1;
        cyc = 0; m_start = 0;
        run_to(15);
        n_checks++;
        if (busy !== 1'b1 || smp_stb !== 1'b0) begin
            n_errors++;
            $display("FAIL areset_settle: got busy=%b smp=%b required 1 0", busy, smp_stb);
        end
        step();
        n_checks++;
        if (smp_stb !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_first_smp: got %b required 1", smp_stb);
        end
        run_to(40);
        stop_to_idle();
    endtask

    initial begin
        test_reset();
        test_word();
        test_overflow();
        test_stop_mid_word();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

endmodule
